trdb_d5m_sensor_emu: RTL and testbench

TRDB_D5M_SENSOR_EMU -- requirements
Module: trdb_d5m_sensor_emu

---
 rtl/trdb_d5m_pkg.sv | 26 ++
 rtl/trdb_d5m_sensor_emu.sv | 219 +++++++++++++++++++++
 tb/tb_trdb_d5m_sensor_emu.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/trdb_d5m_pkg.sv
// Shared types and constants for the TRDB-D5M camera sensor emulator.
package trdb_d5m_pkg;

   // Emulated sensor pixel bus width.
   localparam int PIX_W   = 12;
   // Frame counter width; the counter wraps 255 -> 0.
   localparam int FRAME_W = 8;
   // Width of the column/row/duration counters (legal sizes go up to 4095).
   localparam int CNT_W   = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FV_LEAD,
      ST_LINE,
      ST_HBLANK,
      ST_FV_TRAIL,
      ST_VBLANK
   } emu_state_t;

   // FVAL is high in every state between FV_LEAD entry and VBLANK entry.
   function automatic logic state_in_frame(input emu_state_t s);
      return (s == ST_FV_LEAD) || (s == ST_LINE) ||
             (s == ST_HBLANK)  || (s == ST_FV_TRAIL);
   endfunction

endpackage

// File: rtl/trdb_d5m_sensor_emu.sv
// TRDB-D5M sensor emulator: generates a pixel clock at ul1Clock/2 and a
// FVAL/LVAL framed test pattern (col + row + frame) on the pixel bus.
// All outputs are registered and only change on a pixel tick (the cycle on
// which ul1PixelClock falls), so they are stable at its rising edge.
// Optional feature: define TRDB_D5M_EMU_SNAPSHOT_EN to switch from
// free-running frames to one frame per ul1SnapshotTrigger rising edge.
module trdb_d5m_sensor_emu
   import trdb_d5m_pkg::*;
#(
   parameter int P_COLS      = 16,
   parameter int P_ROWS      = 8,
   parameter int P_HBLANK    = 4,
   parameter int P_VBLANK    = 8,
   parameter int P_FV_LV_GAP = 2
) (
   input  logic             ul1Clock,
   input  logic             ul1Reset_n,
   input  logic             ul1Enable,
   input  logic             ul1SnapshotTrigger,
   output logic             ul1PixelClock,
   output logic [PIX_W-1:0] ul12PixelData,
   output logic             ul1LineValid,
   output logic             ul1FrameValid,
   output logic             ul1SnapshotStrobe
);

   // Last count value of each timed state (states last N ticks: 0..N-1).
   localparam logic [CNT_W-1:0] COLS_LAST   = CNT_W'(P_COLS - 1);
   localparam logic [CNT_W-1:0] ROWS_LAST   = CNT_W'(P_ROWS - 1);
   localparam logic [CNT_W-1:0] HBLANK_LAST = CNT_W'(P_HBLANK - 1);
   localparam logic [CNT_W-1:0] VBLANK_LAST = CNT_W'(P_VBLANK - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(P_FV_LV_GAP - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

   emu_state_t         state_q, state_d;
   logic               pclk_q, pclk_d;
   logic               tick;
   logic [CNT_W-1:0]   dur_q, dur_d;
   logic [CNT_W-1:0]   col_q, col_d;
   logic [CNT_W-1:0]   row_q, row_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               fval_q, fval_d;
   logic               lval_q, lval_d;
   logic               strobe_q, strobe_d;
   logic [PIX_W-1:0]   data_q, data_d;
   logic               start;

   // The pixel clock falls on the edge after a cycle where it is high.
   assign pclk_d = ~pclk_q;
   assign tick   = pclk_q;

`ifdef TRDB_D5M_EMU_SNAPSHOT_EN
   logic trig_q, trig_d;
   logic trig_prev_q, trig_prev_d;
   logic pending_q, pending_d;
   logic trig_edge;

   assign trig_edge = trig_q & ~trig_prev_q;
   assign start     = pending_q;

   // Latch one frame request per trigger edge seen while idle; edges
   // arriving while a frame (including its VBLANK) is in progress are dropped.
   always_comb begin
      trig_d      = ul1SnapshotTrigger;
      trig_prev_d = trig_q;
      pending_d   = pending_q;
      if (state_q != ST_IDLE) begin
         pending_d = 1'b0;
      end else if (tick && pending_q) begin
         pending_d = 1'b0;
      end else if (trig_edge && ul1Enable) begin
         pending_d = 1'b1;
      end
   end

   // Trigger synchroniser, edge history and pending-request flag.
   always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
      if (!ul1Reset_n) begin
         trig_q      <= 1'b0;
         trig_prev_q <= 1'b0;
         pending_q   <= 1'b0;
      end else begin
         trig_q      <= trig_d;
         trig_prev_q <= trig_prev_d;
         pending_q   <= pending_d;
      end
   end
`else
   // Free-running build: the trigger input has no function.
   logic unused_trigger;
   assign unused_trigger = ul1SnapshotTrigger;
   assign start          = ul1Enable;
`endif

   // Next-state, counter and output computation; everything holds between ticks.
   always_comb begin
      state_d = state_q;
      dur_d   = dur_q;
      col_d   = col_q;
      row_d   = row_q;
      frame_d = frame_q;
      if (tick) begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_FV_LEAD;
                  dur_d   = '0;
               end
            end
            ST_FV_LEAD: begin
               if (dur_q == GAP_LAST) begin
                  state_d = ST_LINE;
                  dur_d   = '0;
                  col_d   = '0;
                  row_d   = '0;
               end else begin
                  dur_d = dur_q + CNT_ONE;
               end
            end
            ST_LINE: begin
               if (col_q == COLS_LAST) begin
                  col_d = '0;
                  dur_d = '0;
                  if (row_q == ROWS_LAST) begin
                     // Last row goes straight to the trailing gap, no HBLANK.
                     state_d = ST_FV_TRAIL;
                     row_d   = '0;
                  end else begin
                     state_d = ST_HBLANK;
                  end
               end else begin
                  col_d = col_q + CNT_ONE;
               end
            end
            ST_HBLANK: begin
               if (dur_q == HBLANK_LAST) begin
                  state_d = ST_LINE;
                  dur_d   = '0;
                  col_d   = '0;
                  row_d   = row_q + CNT_ONE;
               end else begin
                  dur_d = dur_q + CNT_ONE;
               end
            end
            ST_FV_TRAIL: begin
               if (dur_q == GAP_LAST) begin
                  state_d = ST_VBLANK;
                  dur_d   = '0;
                  frame_d = frame_q + FRAME_ONE;
               end else begin
                  dur_d = dur_q + CNT_ONE;
               end
            end
            ST_VBLANK: begin
               if (dur_q == VBLANK_LAST) begin
                  // Enable is only sampled here, so dropping it never cuts a frame short.
                  state_d = start ? ST_FV_LEAD : ST_IDLE;
                  dur_d   = '0;
               end else begin
                  dur_d = dur_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               dur_d   = '0;
            end
         endcase
      end

      // Outputs are decoded from the next state so they register on the tick.
      fval_d = state_in_frame(state_d);
      lval_d = (state_d == ST_LINE);
      if (state_d == ST_LINE) begin
         data_d = col_d + row_d + PIX_W'(frame_d);
      end else begin
         data_d = '0;
      end
`ifdef TRDB_D5M_EMU_SNAPSHOT_EN
      strobe_d = fval_d;
`else
      strobe_d = 1'b0;
`endif
   end

   // State, counters and registered outputs; reset aborts any frame at once.
   always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
      if (!ul1Reset_n) begin
         state_q  <= ST_IDLE;
         pclk_q   <= 1'b0;
         dur_q    <= '0;
         col_q    <= '0;
         row_q    <= '0;
         frame_q  <= '0;
         fval_q   <= 1'b0;
         lval_q   <= 1'b0;
         strobe_q <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         pclk_q   <= pclk_d;
         dur_q    <= dur_d;
         col_q    <= col_d;
         row_q    <= row_d;
         frame_q  <= frame_d;
         fval_q   <= fval_d;
         lval_q   <= lval_d;
         strobe_q <= strobe_d;
         data_q   <= data_d;
      end
   end

   assign ul1PixelClock     = pclk_q;
   assign ul12PixelData     = data_q;
   assign ul1LineValid      = lval_q;
   assign ul1FrameValid     = fval_q;
   assign ul1SnapshotStrobe = strobe_q;

endmodule

// File: tb/tb_trdb_d5m_sensor_emu.sv
// Directed testbench for trdb_d5m_sensor_emu: a default-size instance and a
// 1x1 instance share clock, reset and enable.
`timescale 1ns/1ps
module tb_trdb_d5m_sensor_emu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        trig = 1'b0;
   logic        pclk, lval, fval, strobe;
   logic [11:0] data;
   logic        pclk_b, lval_b, fval_b, strobe_b;
   logic [11:0] data_b;

   int n_tests = 0;
   int n_fail  = 0;
   int row_first [8];
   int row_last  [8];
   int fv, pulses, lv, bad, vb;

   always #5 clk = ~clk;

   trdb_d5m_sensor_emu dut (
      .ul1Clock           (clk),
      .ul1Reset_n         (rst_n),
      .ul1Enable          (en),
      .ul1SnapshotTrigger (trig),
      .ul1PixelClock      (pclk),
      .ul12PixelData      (data),
      .ul1LineValid       (lval),
      .ul1FrameValid      (fval),
      .ul1SnapshotStrobe  (strobe)
   );

   trdb_d5m_sensor_emu #(.P_COLS(1), .P_ROWS(1)) dut_b (
      .ul1Clock           (clk),
      .ul1Reset_n         (rst_n),
      .ul1Enable          (en),
      .ul1SnapshotTrigger (trig),
      .ul1PixelClock      (pclk_b),
      .ul12PixelData      (data_b),
      .ul1LineValid       (lval_b),
      .ul1FrameValid      (fval_b),
      .ul1SnapshotStrobe  (strobe_b)
   );

   task automatic check(input string tag, input int obs, input int expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Advance to the negedge just after the next pixel tick.
   task automatic next_tick();
      int guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (pclk !== 1'b0 && guard < 4);
   endtask

   // Called on the first FVAL-high tick of a frame; walks it and the VBLANK after.
   task automatic observe_frame(input int frm, input int drop_row,
                                output int o_fv, output int o_pulses, output int o_lv,
                                output int o_bad, output int o_vb);
      int col = 0;
      int rowi = 0;
      logic prev = 1'b0;
      logic [11:0] expv;
      o_fv = 0; o_pulses = 0; o_lv = 0; o_bad = 0; o_vb = 0;
      while (fval === 1'b1 && o_fv < 5000) begin
         o_fv++;
         trig = o_fv[2];
         if (strobe !== 1'b0) o_bad++;
         if (lval === 1'b1) begin
            if (prev !== 1'b1) begin
               o_pulses++;
               col = 0;
               if (o_pulses - 1 == drop_row) en = 1'b0;
            end
            rowi = o_pulses - 1;
            expv = 12'((col + rowi + frm) % 4096);
            if (data !== expv) o_bad++;
            if (rowi < 8) begin
               if (col == 0) row_first[rowi] = int'(data);
               row_last[rowi] = int'(data);
            end
            o_lv++;
            col++;
         end else if (data !== 12'd0) begin
            o_bad++;
         end
         prev = lval;
         next_tick();
      end
      trig = 1'b0;
      while (fval === 1'b0 && o_vb < 300) begin
         if (lval !== 1'b0 || data !== 12'd0 || strobe !== 1'b0) o_bad++;
         o_vb++;
         next_tick();
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, k, p, bframe, b_fv0, b_lv0, bad_b, d255, d256, got256;
      int strobe_ticks, fval_rises;
      logic prev;

      rst_n = 1'b0; en = 1'b0; trig = 1'b0;
      repeat (3) @(negedge clk);
      en = 1'b1;
      trig = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_pclk",   int'(pclk),   0);
      check("rst_lval",   int'(lval),   0);
      check("rst_fval",   int'(fval),   0);
      check("rst_data",   int'(data),   0);
      check("rst_strobe", int'(strobe), 0);
      trig = 1'b0;

`ifdef TRDB_D5M_EMU_SNAPSHOT_EN
      // Snapshot build: no frame without a trigger, one frame for two edges.
      rst_n = 1'b1;
      k = 0;
      for (int t = 0; t < 40; t++) begin
         next_tick();
         if (fval === 1'b1) k++;
      end
      check("snap_idle_no_trigger", k, 0);
      strobe_ticks = 0; fval_rises = 0; prev = 1'b0;
      for (int t = 0; t < 600; t++) begin
         if (t == 1)  trig = 1'b1;
         if (t == 3)  trig = 1'b0;
         if (t == 11) trig = 1'b1;
         if (t == 13) trig = 1'b0;
         next_tick();
         if (strobe === 1'b1) strobe_ticks++;
         if (fval === 1'b1 && prev !== 1'b1) fval_rises++;
         prev = fval;
      end
      check("snap_frames", fval_rises, 1);
      check("snap_strobe_ticks", strobe_ticks, 160);
      check("snap_idle_fval", int'(fval), 0);
`else
      // Free-run from reset release: first tick starts the frame.
      rst_n = 1'b1;
      next_tick();
      check("start_first_tick_fval", int'(fval), 1);

      observe_frame(0, -1, fv, pulses, lv, bad, vb);
      check("f0_fval_ticks", fv, 160);
      check("f0_lval_pulses", pulses, 8);
      check("f0_lval_ticks", lv, 128);
      check("f0_vblank_ticks", vb, 8);
      check("f0_bad_pixels", bad, 0);
      check("f0_row2_first", row_first[2], 2);
      check("f0_row2_last", row_last[2], 17);

      observe_frame(1, -1, fv, pulses, lv, bad, vb);
      check("f1_bad_pixels", bad, 0);
      observe_frame(2, -1, fv, pulses, lv, bad, vb);
      check("f2_bad_pixels", bad, 0);
      observe_frame(3, -1, fv, pulses, lv, bad, vb);
      check("f3_bad_pixels", bad, 0);
      check("f3_row0_first", row_first[0], 3);
      check("f3_row0_last", row_last[0], 18);
      check("f3_period", fv + vb, 168);

      // Enable dropped on row 4: frame completes, then stays idle.
      observe_frame(4, 4, fv, pulses, lv, bad, vb);
      check("drop_fval_ticks", fv, 160);
      check("drop_lval_pulses", pulses, 8);
      check("drop_bad_pixels", bad, 0);
      check("drop_idle_window", vb, 300);
      check("drop_idle_fval", int'(fval), 0);
      check("drop_idle_lval", int'(lval), 0);
      check("drop_idle_data", int'(data), 0);

      // Reset pulsed on row 3 of a running frame.
      en = 1'b1;
      k = 0; p = 0; prev = 1'b0;
      while (p < 4 && k < 1000) begin
         next_tick();
         k++;
         if (lval === 1'b1 && prev !== 1'b1) p++;
         prev = lval;
      end
      check("rst_mid_reached_row3", p, 4);
      check("rst_mid_lval_before", int'(lval), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_lval", int'(lval), 0);
      check("rst_async_fval", int'(fval), 0);
      check("rst_async_data", int'(data), 0);
      check("rst_async_pclk", int'(pclk), 0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      do begin
         next_tick();
         n++;
      end while (fval !== 1'b1 && n < 10);
      check("rst_restart_within_2", int'(n <= 2), 1);
      observe_frame(0, -1, fv, pulses, lv, bad, vb);
      check("rst_restart_fval_ticks", fv, 160);
      check("rst_restart_bad_pixels", bad, 0);

      // 1x1 instance: frame shape and 8-bit frame counter wrap.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bframe = 0; b_fv0 = 0; b_lv0 = 0; bad_b = 0; d255 = -1; d256 = -1; got256 = 0;
      prev = 1'b0;
      for (int t = 0; t < 4000 && got256 == 0; t++) begin
         next_tick();
         if (fval_b === 1'b1 && prev !== 1'b1) bframe++;
         prev = fval_b;
         if (bframe == 1 && fval_b === 1'b1) begin
            b_fv0++;
            if (lval_b === 1'b1) b_lv0++;
         end
         if (lval_b === 1'b1) begin
            if (data_b !== 12'((bframe - 1) % 256)) bad_b++;
            if (bframe - 1 == 255) d255 = int'(data_b);
            if (bframe - 1 == 256) begin
               d256 = int'(data_b);
               got256 = 1;
            end
         end
      end
      check("b_f0_fval_ticks", b_fv0, 5);
      check("b_f0_lval_ticks", b_lv0, 1);
      check("b_reached_frame256", got256, 1);
      check("b_frame255_data", d255, 255);
      check("b_frame256_wrap_data", d256, 0);
      check("b_bad_pixels", bad_b, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
